// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter.
// Port ids, access sizes and the default lock burst limit.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_HALF = 2'd1,
    RAM_WORD = 2'd2
  } ram_size_e;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_port_e;

  localparam int RAM_ARB_MAX_BURST = 4;

  function automatic logic [1:0] port_onehot(
    input arb_port_e p
  );
    return (p == ARB_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin chooser with an optional lock owner.
// Grant is one-hot or zero and purely combinational.
module ram_arbiter_rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  arb_port_e  i_last,
  input  logic       i_lock_act,
  input  arb_port_e  i_owner,
  output logic [1:0] o_grant
);

  arb_port_e w_last;
  logic      w_owner_vld;

  // A lock holder that dropped valid counts as the last winner.
  assign w_last = i_lock_act ? i_owner : i_last;
  assign w_owner_vld = (i_owner == ARB_DMA)
                     ? i_valid[1] : i_valid[0];

  always_comb begin
    o_grant = 2'b00;
    if (i_lock_act && w_owner_vld) begin
      o_grant = port_onehot(i_owner);
    end else begin
      unique case (i_valid)
        2'b11: o_grant = (w_last == ARB_CPU)
                       ? 2'b10 : 2'b01;
        2'b01: o_grant = 2'b01;
        2'b10: o_grant = 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the data RAM between CPU and DMA.
// Define RAM_ARB_LOCK_EN to enable burst locking via req_lock_i.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = RAM_ARB_MAX_BURST
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][DATA_W-1:0] req_wdata_i,
  input  ram_size_e [1:0]        req_size_i,
  input  logic [1:0]             req_unsigned_i,
  input  logic [1:0]             req_lock_i,
  output logic [1:0]             rsp_valid_o,
  output logic [1:0][DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic [DATA_W-1:0]      ram_wdata_o,
  output ram_size_e              ram_size_o,
  output logic                   ram_unsigned_o,
  output logic                   ram_we_o,
  input  logic [DATA_W-1:0]      ram_rdata_i
);

  logic [1:0]        w_pick;
  logic [1:0]        w_grant;
  logic              w_any;
  logic              w_sel;
  arb_port_e         w_idx;
  logic              w_load;
  logic              w_lock_act;
  arb_port_e         w_owner;

  arb_port_e         r_last;
  logic              r_rsp_pend;
  arb_port_e         r_rsp_port;
  logic [DATA_W-1:0] r_rdata;

  ram_arbiter_rr_pick u_pick (
    .i_valid    (req_valid_i),
    .i_last     (r_last),
    .i_lock_act (w_lock_act),
    .i_owner    (w_owner),
    .o_grant    (w_pick)
  );

  // Held in reset: nothing is granted and no store reaches the RAM.
  assign w_grant = w_pick & {2{reset_n}};
  assign w_any   = |w_grant;
  assign w_sel   = w_grant[1];
  assign w_idx   = arb_port_e'(w_sel);
  assign w_load  = w_any & ~req_we_i[w_sel];

  assign req_ready_o    = w_grant;
  assign ram_addr_o     = w_any ? req_addr_i[w_sel] : '0;
  assign ram_wdata_o    = w_any ? req_wdata_i[w_sel] : '0;
  assign ram_size_o     = w_any ? req_size_i[w_sel] : RAM_BYTE;
  assign ram_unsigned_o = w_any & req_unsigned_i[w_sel];
  assign ram_we_o       = w_any & req_we_i[w_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= ARB_DMA;
      r_rsp_pend <= 1'b0;
      r_rsp_port <= ARB_CPU;
      r_rdata    <= '0;
    end else begin
      r_rsp_pend <= w_load;
      if (w_any) begin
        r_last <= w_idx;
      end
      if (w_load) begin
        r_rsp_port <= w_idx;
        r_rdata    <= ram_rdata_i;
      end
    end
  end

  assign rsp_valid_o = r_rsp_pend
                     ? port_onehot(r_rsp_port) : 2'b00;
  assign rsp_rdata_o[0] = r_rdata;
  assign rsp_rdata_o[1] = r_rdata;

`ifdef RAM_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic          r_lock_act;
  arb_port_e     r_owner;
  logic [CW-1:0] r_cnt;
  logic          w_lock_nxt;
  arb_port_e     w_owner_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Beat count includes the beat that took the lock.
  always_comb begin
    w_lock_nxt  = 1'b0;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = '0;
    if (w_any && req_lock_i[w_sel]) begin
      if (r_lock_act && w_idx == r_owner) begin
        if (r_cnt < CW'(MAX_BURST - 1)) begin
          w_lock_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end else if (MAX_BURST > 1) begin
        w_lock_nxt  = 1'b1;
        w_owner_nxt = w_idx;
        w_cnt_nxt   = CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_act <= 1'b0;
      r_owner    <= ARB_CPU;
      r_cnt      <= '0;
    end else begin
      r_lock_act <= w_lock_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign w_lock_act = r_lock_act;
  assign w_owner    = r_owner;
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock_i ^ (MAX_BURST < 1);
  assign w_lock_act    = 1'b0;
  assign w_owner       = ARB_CPU;
`endif

endmodule
